// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX stage: default widths, ALU/forwarding encodings,
// and the packed control bundle whose all-zero value is the pipeline NOP.
package id_ex_stage_reg_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int ALUOP_W_DEF = 4;
  localparam int CNT_W_DEF   = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose (non-x0) destination
// is read by the instruction currently in ID.
module id_ex_stage_reg_load_use_detect
  import id_ex_stage_reg_pkg::*;
#(
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               idex_mem_read_i,
  input  logic [RADDR_W-1:0] idex_rd_i,
  input  logic [RADDR_W-1:0] id_rs1_i,
  input  logic [RADDR_W-1:0] id_rs2_i,
  output logic               load_use_o
);

  assign load_use_o = idex_mem_read_i && (idex_rd_i != '0) &&
                      ((idex_rd_i == id_rs1_i) || (idex_rd_i == id_rs2_i));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// One cycle ID->IDEX; pc_write/ifid_write are combinational from the current hazard.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ext_stall,
  input  logic [RADDR_W-1:0] ID_rs1,
  input  logic [RADDR_W-1:0] ID_rs2,
  input  logic [RADDR_W-1:0] ID_rd,
  input  logic [XLEN-1:0]    ID_rs1_data,
  input  logic [XLEN-1:0]    ID_rs2_data,
  input  logic [XLEN-1:0]    ID_imm,
  input  logic [XLEN-1:0]    ID_pc,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_ALUSrc,
  input  logic               ID_Branch,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  output logic [RADDR_W-1:0] IDEX_rs1,
  output logic [RADDR_W-1:0] IDEX_rs2,
  output logic [RADDR_W-1:0] IDEX_rd,
  output logic [XLEN-1:0]    IDEX_rs1_data,
  output logic [XLEN-1:0]    IDEX_rs2_data,
  output logic [XLEN-1:0]    IDEX_imm,
  output logic [XLEN-1:0]    IDEX_pc,
  output logic               IDEX_WriteBack,
  output logic               IDEX_MemRead,
  output logic               IDEX_MemWrite,
  output logic               IDEX_MemToReg,
  output logic               IDEX_ALUSrc,
  output logic               IDEX_Branch,
  output logic [ALUOP_W-1:0] IDEX_ALUOp,
  output logic               pc_write,
  output logic               ifid_write,
  output logic [CNT_W-1:0]   bubble_count
);

  ctrl_t               ctrl_q, ctrl_d, id_ctrl;
  logic [ALUOP_W-1:0]  alu_op_q, alu_op_d;
  logic [RADDR_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]     rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]     imm_q, imm_d, pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_use, bubble, load_data, load_ctrl, kill_ctrl;

  id_ex_stage_reg_load_use_detect #(.RADDR_W(RADDR_W)) u_lud (
    .idex_mem_read_i (ctrl_q.mem_read),
    .idex_rd_i       (rd_q),
    .id_rs1_i        (ID_rs1),
    .id_rs2_i        (ID_rs2),
    .load_use_o      (load_use)
  );

  // Flush outranks the hazard: the squashed ID instruction cannot cause a stall.
  assign bubble     = load_use & ~flush & ~ext_stall;
  assign pc_write   = ~(load_use & ~flush) & ~ext_stall;
  assign ifid_write = pc_write;

  assign load_data = flush | (~ext_stall & ~load_use);
  assign kill_ctrl = flush | (~ext_stall & load_use);
  assign load_ctrl = ~flush & ~ext_stall & ~load_use;

  // Writes to x0 are dropped here so forwarding can compare rd without an x0 check.
  assign id_ctrl = '{reg_write:  ID_RegWrite & (ID_rd != '0),
                     mem_read:   ID_MemRead,
                     mem_write:  ID_MemWrite,
                     mem_to_reg: ID_MemToReg,
                     alu_src:    ID_ALUSrc,
                     branch:     ID_Branch};

  always_comb begin
    ctrl_d     = ctrl_q;
    alu_op_d   = alu_op_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    if (load_data) begin
      rs1_d      = ID_rs1;
      rs2_d      = ID_rs2;
      rd_d       = ID_rd;
      rs1_data_d = ID_rs1_data;
      rs2_data_d = ID_rs2_data;
      imm_d      = ID_imm;
      pc_d       = ID_pc;
    end
    if (kill_ctrl) begin
      ctrl_d   = CTRL_NOP;
      alu_op_d = '0;
    end else if (load_ctrl) begin
      ctrl_d   = id_ctrl;
      alu_op_d = ID_ALUOp;
    end
    if (bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= CTRL_NOP;
      alu_op_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      cnt_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      alu_op_q   <= alu_op_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign IDEX_rs1       = rs1_q;
  assign IDEX_rs2       = rs2_q;
  assign IDEX_rd        = rd_q;
  assign IDEX_rs1_data  = rs1_data_q;
  assign IDEX_rs2_data  = rs2_data_q;
  assign IDEX_imm       = imm_q;
  assign IDEX_pc        = pc_q;
  assign IDEX_WriteBack = ctrl_q.reg_write;
  assign IDEX_MemRead   = ctrl_q.mem_read;
  assign IDEX_MemWrite  = ctrl_q.mem_write;
  assign IDEX_MemToReg  = ctrl_q.mem_to_reg;
  assign IDEX_ALUSrc    = ctrl_q.alu_src;
  assign IDEX_Branch    = ctrl_q.branch;
  assign IDEX_ALUOp     = alu_op_q;
  assign bubble_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed-vector bench for id_ex_stage_reg (4-bit counter build) with a queue-based
// scoreboard: the driver pushes each vector's expectations, a monitor pops and compares.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, ext_stall = 1'b0;
  logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, ID_rd = '0;
  logic [31:0] ID_rs1_data = '0, ID_rs2_data = '0, ID_imm = '0, ID_pc = '0;
  logic        ID_RegWrite = 1'b0, ID_MemRead = 1'b0, ID_MemWrite = 1'b0;
  logic        ID_MemToReg = 1'b0, ID_ALUSrc = 1'b0, ID_Branch = 1'b0;
  logic [3:0]  ID_ALUOp = '0;
  logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
  logic [31:0] IDEX_rs1_data, IDEX_rs2_data, IDEX_imm, IDEX_pc;
  logic        IDEX_WriteBack, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc, IDEX_Branch;
  logic [3:0]  IDEX_ALUOp;
  logic        pc_write, ifid_write;
  logic [3:0]  bubble_count;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32), .RADDR_W(5), .ALUOP_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ext_stall(ext_stall),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm), .ID_pc(ID_pc),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_Branch(ID_Branch), .ID_ALUOp(ID_ALUOp),
    .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
    .IDEX_rs1_data(IDEX_rs1_data), .IDEX_rs2_data(IDEX_rs2_data), .IDEX_imm(IDEX_imm), .IDEX_pc(IDEX_pc),
    .IDEX_WriteBack(IDEX_WriteBack), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
    .IDEX_MemToReg(IDEX_MemToReg), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_Branch(IDEX_Branch),
    .IDEX_ALUOp(IDEX_ALUOp), .pc_write(pc_write), .ifid_write(ifid_write),
    .bubble_count(bubble_count)
  );

  // c3 packs {MemWrite, ALUSrc, Branch}; MemToReg is driven equal to MemRead.
  typedef struct {
    bit          rst, flush, stall;
    logic [4:0]  rs1, rs2, rd;
    bit          regw, memr;
    logic [3:0]  alu;
    logic [2:0]  c3;
    logic [31:0] d1;
    int          e_pcw;
    bit          e_wb, e_mr;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [3:0]  e_alu;
    logic [2:0]  e_c3;
    logic [31:0] e_d1;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t stim[$];
  vec_t sb[$];
  int   n_chk = 0, n_pass = 0;
  bit   busy = 1'b0;

  task automatic addv(input bit r, f, s, input logic [4:0] rs1, rs2, rd, input bit regw, memr,
                      input logic [3:0] alu, input logic [2:0] c3, input logic [31:0] d1,
                      input int e_pcw, input bit e_wb, e_mr, input logic [4:0] e_rd, e_rs1, e_rs2,
                      input logic [3:0] e_alu, input logic [2:0] e_c3, input logic [31:0] e_d1,
                      input logic [3:0] e_cnt);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = s; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.regw = regw; v.memr = memr; v.alu = alu; v.c3 = c3; v.d1 = d1;
    v.e_pcw = e_pcw; v.e_wb = e_wb; v.e_mr = e_mr; v.e_rd = e_rd; v.e_rs1 = e_rs1;
    v.e_rs2 = e_rs2; v.e_alu = e_alu; v.e_c3 = e_c3; v.e_d1 = e_d1; v.e_cnt = e_cnt;
    stim.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: combinational outputs checked mid-cycle, registered outputs just after the edge.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        busy = 1'b1;
        e = sb.pop_front();
        if (e.e_pcw >= 0) begin
          chk("pc_write", {31'd0, pc_write}, e.e_pcw[31:0]);
          chk("ifid_write", {31'd0, ifid_write}, e.e_pcw[31:0]);
        end
        @(posedge clk);
        #1;
        chk("writeback", {31'd0, IDEX_WriteBack}, {31'd0, e.e_wb});
        chk("memread", {31'd0, IDEX_MemRead}, {31'd0, e.e_mr});
        chk("memtoreg", {31'd0, IDEX_MemToReg}, {31'd0, e.e_mr});
        chk("ctl3", {29'd0, IDEX_MemWrite, IDEX_ALUSrc, IDEX_Branch}, {29'd0, e.e_c3});
        chk("aluop", {28'd0, IDEX_ALUOp}, {28'd0, e.e_alu});
        chk("rd", {27'd0, IDEX_rd}, {27'd0, e.e_rd});
        chk("rs1", {27'd0, IDEX_rs1}, {27'd0, e.e_rs1});
        chk("rs2", {27'd0, IDEX_rs2}, {27'd0, e.e_rs2});
        chk("rs1_data", IDEX_rs1_data, e.e_d1);
        chk("rs2_data", IDEX_rs2_data, (e.e_d1 == 32'd0) ? 32'd0 : (e.e_d1 ^ 32'hFFFF_0000));
        chk("imm", IDEX_imm, (e.e_d1 == 32'd0) ? 32'd0 : (e.e_d1 + 32'd4));
        chk("pc", IDEX_pc, e.e_d1 << 2);
        chk("bubble_count", {28'd0, bubble_count}, {28'd0, e.e_cnt});
        busy = 1'b0;
      end
    end
  end

  initial begin
    vec_t v;
    // Reset with random ID inputs; first cycle's pc_write follows pre-reset state, so skipped.
    addv(1,0,0, 0,0,0, 0,0, 0,3'b000, 32'h0,    -1, 0,0, 0,0,0, 0,3'b000, 32'h0, 4'd0);
    addv(1,0,0, 0,0,0, 0,0, 0,3'b000, 32'h0,     1, 0,0, 0,0,0, 0,3'b000, 32'h0, 4'd0);
    // lw x5 then dependent add: one bubble, then the add loads.
    addv(0,0,0, 1,2,5,  1,1, 0,3'b010, 32'h100,  1, 1,1, 5,1,2, 0,3'b010, 32'h100, 4'd0);
    addv(0,0,0, 5,6,7,  1,0, 1,3'b000, 32'h200,  0, 0,0, 5,1,2, 0,3'b000, 32'h100, 4'd1);
    addv(0,0,0, 5,6,7,  1,0, 1,3'b000, 32'h200,  1, 1,0, 7,5,6, 1,3'b000, 32'h200, 4'd1);
    // x0 destination: no writeback, and a load to x0 causes no stall.
    addv(0,0,0, 3,4,0,  1,1, 2,3'b010, 32'h300,  1, 0,1, 0,3,4, 2,3'b010, 32'h300, 4'd1);
    addv(0,0,0, 0,0,8,  1,0, 3,3'b000, 32'h400,  1, 1,0, 8,0,0, 3,3'b000, 32'h400, 4'd1);
    // Flush concurrent with load-use: bubble without stall or count; data still loads.
    addv(0,0,0, 1,2,9,  1,1, 0,3'b010, 32'h500,  1, 1,1, 9,1,2, 0,3'b010, 32'h500, 4'd1);
    addv(0,1,0, 9,0,10, 1,0, 4,3'b001, 32'h600,  1, 0,0, 10,9,0, 0,3'b000, 32'h600, 4'd1);
    // Load in EX, then 3 stall cycles with a pending hazard and changing ID inputs.
    addv(0,0,0, 11,12,13, 1,1, 5,3'b100, 32'h700, 1, 1,1, 13,11,12, 5,3'b100, 32'h700, 4'd1);
    addv(0,0,1, 13,2,3,   0,1, 6,3'b011, 32'h800, 0, 1,1, 13,11,12, 5,3'b100, 32'h700, 4'd1);
    addv(0,0,1, 13,4,14,  1,0, 7,3'b111, 32'h900, 0, 1,1, 13,11,12, 5,3'b100, 32'h700, 4'd1);
    addv(0,0,1, 13,5,6,   1,1, 1,3'b001, 32'hA00, 0, 1,1, 13,11,12, 5,3'b100, 32'h700, 4'd1);
    addv(0,0,0, 13,0,15,  1,0, 7,3'b000, 32'hB00, 0, 0,0, 13,11,12, 0,3'b000, 32'h700, 4'd2);
    addv(0,0,0, 13,0,15,  1,0, 7,3'b000, 32'hB00, 1, 1,0, 15,13,0, 7,3'b000, 32'hB00, 4'd2);
    // Back-to-back "lw x20,0(x20)": alternating load/bubble until the 4-bit counter saturates.
    for (int k = 0; k < 15; k++) begin
      addv(0,0,0, 20,0,20, 1,1, 0,3'b010, 32'hC00, 1, 1,1, 20,20,0, 0,3'b010, 32'hC00,
           4'((2 + k > 15) ? 15 : 2 + k));
      addv(0,0,0, 20,0,20, 1,1, 0,3'b010, 32'hC00, 0, 0,0, 20,20,0, 0,3'b000, 32'hC00,
           4'((3 + k > 15) ? 15 : 3 + k));
    end
    // Reset during a pending hazard clears everything, then the counter restarts.
    addv(0,0,0, 20,0,20, 1,1, 0,3'b010, 32'hC00, 1, 1,1, 20,20,0, 0,3'b010, 32'hC00, 4'd15);
    addv(1,0,0, 20,0,20, 1,1, 0,3'b010, 32'hC00, 0, 0,0, 0,0,0,   0,3'b000, 32'h0,   4'd0);
    addv(0,0,0, 20,0,20, 1,1, 0,3'b010, 32'hC00, 1, 1,1, 20,20,0, 0,3'b010, 32'hC00, 4'd0);
    addv(0,0,0, 20,0,20, 1,1, 0,3'b010, 32'hC00, 0, 0,0, 20,20,0, 0,3'b000, 32'hC00, 4'd1);

    for (int i = 0; i < stim.size(); i++) begin
      v = stim[i];
      @(negedge clk);
      rst = v.rst; flush = v.flush; ext_stall = v.stall;
      if (i < 2) begin
        ID_rs1 = 5'($urandom); ID_rs2 = 5'($urandom); ID_rd = 5'($urandom);
        ID_rs1_data = $urandom; ID_rs2_data = $urandom; ID_imm = $urandom; ID_pc = $urandom;
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_Branch} = 6'($urandom);
        ID_ALUOp = 4'($urandom);
      end else begin
        ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_rd = v.rd;
        ID_rs1_data = v.d1; ID_rs2_data = v.d1 ^ 32'hFFFF_0000;
        ID_imm = v.d1 + 32'd4; ID_pc = v.d1 << 2;
        ID_RegWrite = v.regw; ID_MemRead = v.memr; ID_MemToReg = v.memr;
        {ID_MemWrite, ID_ALUSrc, ID_Branch} = v.c3;
        ID_ALUOp = v.alu;
      end
      sb.push_back(v);
    end

    for (int t = 0; t < 50 && (sb.size() != 0 || busy); t++) @(posedge clk);
    #3;
    if (sb.size() != 0 || busy) begin
      n_chk++;
      $display("FAIL drain: %0d entries still pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
